pwm_cfg_sequencer: RTL and testbench

- Host-side configuration controller for the two-channel PWM peripheral.
- Accepts one configuration request at a time (channel, divisor, period, duty, enable) over a valid/ready handshake and checks it against the PWM legality rules.
- Legal requests are turned into an ordered burst of single-cycle register writes on the PWM write bus: disable, divisor, period, duty, enable.
- Illegal requests are rejected without touching the peripheral. Sits between the SweRV-side host logic and the pwm register port.

---
 rtl/pwm_cfg_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer
// Host-side configuration controller for the two-channel PWM peripheral.
// Takes one configuration request at a time over valid/ready and checks it
// against the PWM legality rules. A legal request becomes an ordered burst of
// single-cycle register writes: disable, divisor, period, duty, enable.
// A disable-only request (req_en_i=0) issues just the disable write.
// An illegal request is rejected with an err_o pulse and no writes.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  request present        req_ready_o  request can be accepted
//   req_ch_i     0 = channel 1, 1 = channel 2
//   req_en_i     1 = reconfigure + enable, 0 = disable only
//   req_div_i    divisor                req_per_i    period
//   req_dc_i     duty cycle
//   busy_o       sequence in progress
//   done_o       one-cycle pulse, sequence finished
//   err_o        one-cycle pulse, request rejected
//   write_o      PWM register write enable
//   addr_o       PWM register address
//   wdata_o      PWM write data
module pwm_cfg_sequencer #(
    parameter logic [7:0]  CH2_BASE = 8'h10,
    parameter logic [31:0] CTRL_ON  = 32'd7,
    parameter logic [31:0] CTRL_OFF = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_ch_i,
    input  logic        req_en_i,
    input  logic [31:0] req_div_i,
    input  logic [31:0] req_per_i,
    input  logic [31:0] req_dc_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        write_o,
    output logic [7:0]  addr_o,
    output logic [31:0] wdata_o
);

    localparam logic [7:0] ADDR_CTRL = 8'd0;
    localparam logic [7:0] ADDR_DIV  = 8'd4;
    localparam logic [7:0] ADDR_PER  = 8'd8;
    localparam logic [7:0] ADDR_DC   = 8'd12;

    typedef enum logic [2:0] {
        StIdle, StErr, StWOff, StWDiv, StWPer, StWDc, StWOn, StFin
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    // Captured request
    logic        r_ch;
    logic        r_en;
    logic [31:0] r_div;
    logic [31:0] r_per;
    logic [31:0] r_dc;

    // Registered outputs
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_write;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_illegal;
    logic        w_ch;
    logic [7:0]  w_base;
    logic        w_write_d;
    logic        w_done_d;
    logic        w_err_d;
    logic [7:0]  w_addr_d;
    logic [31:0] w_wdata_d;

    assign w_accept  = req_valid_i & r_ready;
    assign w_illegal = (req_div_i == 32'd0) | (req_per_i == 32'd0) | (req_dc_i >= req_per_i);

    // The disable write is decoded on the accepting edge, before r_ch is loaded.
    assign w_ch   = (r_state == StIdle) ? req_ch_i : r_ch;
    assign w_base = w_ch ? CH2_BASE : 8'h00;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (req_en_i && w_illegal) ? StErr : StWOff;
                end
            end
            StErr:   w_state_next = StIdle;
            StWOff:  w_state_next = r_en ? StWDiv : StFin;
            StWDiv:  w_state_next = StWPer;
            StWPer:  w_state_next = StWDc;
            StWDc:   w_state_next = StWOn;
            StWOn:   w_state_next = StFin;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        w_write_d = 1'b0;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        unique case (w_state_next)
            StErr:  w_err_d = 1'b1;
            StWOff: begin
                w_write_d = 1'b1;
                w_addr_d  = w_base + ADDR_CTRL;
                w_wdata_d = CTRL_OFF;
            end
            StWDiv: begin
                w_write_d = 1'b1;
                w_addr_d  = w_base + ADDR_DIV;
                w_wdata_d = r_div;
            end
            StWPer: begin
                w_write_d = 1'b1;
                w_addr_d  = w_base + ADDR_PER;
                w_wdata_d = r_per;
            end
            StWDc: begin
                w_write_d = 1'b1;
                w_addr_d  = w_base + ADDR_DC;
                w_wdata_d = r_dc;
            end
            StWOn: begin
                w_write_d = 1'b1;
                w_addr_d  = w_base + ADDR_CTRL;
                w_wdata_d = CTRL_ON;
            end
            StFin:  w_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_ch    <= 1'b0;
            r_en    <= 1'b0;
            r_div   <= 32'd0;
            r_per   <= 32'd0;
            r_dc    <= 32'd0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_ch  <= req_ch_i;
                r_en  <= req_en_i;
                r_div <= req_div_i;
                r_per <= req_per_i;
                r_dc  <= req_dc_i;
            end
            r_ready <= (w_state_next == StIdle);
            r_busy  <= (w_state_next != StIdle);
            r_done  <= w_done_d;
            r_err   <= w_err_d;
            r_write <= w_write_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign write_o     = r_write;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Self-checking bench for pwm_cfg_sequencer. A queue-based model expands each
// accepted request into the per-cycle output pattern it must produce; a
// negedge process compares the DUT against it every cycle. Literal write logs
// pin the model for the directed scenarios.
module tb_pwm_cfg_sequencer;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_ch_i;
    logic        req_en_i;
    logic [31:0] req_div_i;
    logic [31:0] req_per_i;
    logic [31:0] req_dc_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        write_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;

    pwm_cfg_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_ch_i    (req_ch_i),
        .req_en_i    (req_en_i),
        .req_div_i   (req_div_i),
        .req_per_i   (req_per_i),
        .req_dc_i    (req_dc_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .write_o     (write_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic        dn;
        logic        er;
    } ev_t;

    ev_t         m_q[$];
    ev_t         cur;
    bit          m_idle = 1'b1;
    bit          m_live = 1'b0;
    logic [7:0]  m_addr = 8'd0;
    logic [31:0] m_data = 32'd0;

    // Observation log of the DUT bus, reset by the stimulus between scenarios.
    logic [39:0] obs[$];
    logic [39:0] exp_log[$];
    int          n_done = 0;
    int          n_err  = 0;

    function automatic ev_t wr_ev(input logic [7:0] a, input logic [31:0] d);
        ev_t e;
        e = '0;
        e.wr = 1'b1;
        e.a  = a;
        e.d  = d;
        return e;
    endfunction

    task automatic model_accept();
        ev_t        e;
        logic [7:0] base;
        base = req_ch_i ? 8'h10 : 8'h00;
        if (req_en_i && (req_div_i == 0 || req_per_i == 0 || !(req_dc_i < req_per_i))) begin
            e = '0;
            e.er = 1'b1;
            m_q.push_back(e);
        end else begin
            m_q.push_back(wr_ev(base, 32'd0));
            if (req_en_i) begin
                m_q.push_back(wr_ev(base + 8'd4, req_div_i));
                m_q.push_back(wr_ev(base + 8'd8, req_per_i));
                m_q.push_back(wr_ev(base + 8'd12, req_dc_i));
                m_q.push_back(wr_ev(base, 32'd7));
            end
            e = '0;
            e.dn = 1'b1;
            m_q.push_back(e);
        end
    endtask

    // Inputs only change 1 time unit after a negedge, so what is seen here is
    // exactly what the DUT sampled at the preceding rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                m_q.delete();
                cur    = '0;
                m_idle = 1'b1;
                m_addr = 8'd0;
                m_data = 32'd0;
                m_live = 1'b1;
            end else if (m_live) begin
                if (m_idle && req_valid_i) model_accept();
                if (m_q.size() > 0) begin
                    cur    = m_q.pop_front();
                    m_idle = 1'b0;
                    if (cur.wr) begin
                        m_addr = cur.a;
                        m_data = cur.d;
                    end
                end else begin
                    cur    = '0;
                    m_idle = 1'b1;
                end
            end
            if (m_live) begin
                chk("ready", 64'(req_ready_o), 64'(m_idle));
                chk("busy", 64'(busy_o), 64'(!m_idle));
                chk("write", 64'(write_o), 64'(cur.wr));
                chk("done", 64'(done_o), 64'(cur.dn));
                chk("err", 64'(err_o), 64'(cur.er));
                chk("addr", 64'(addr_o), 64'(m_addr));
                chk("wdata", 64'(wdata_o), 64'(m_data));
            end
            if (write_o) obs.push_back({addr_o, wdata_o});
            if (done_o) n_done++;
            if (err_o) n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_log();
        obs.delete();
        exp_log.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [31:0] d);
        exp_log.push_back({a, d});
    endtask

    task automatic check_log(input string name);
        chk({name, "_nwrites"}, 64'(obs.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_wr%0d", name, i), 64'(obs[i]), 64'(exp_log[i]));
        end
    endtask

    task automatic drive(input logic ch, input logic en, input logic [31:0] dv,
                         input logic [31:0] pr, input logic [31:0] dc);
        req_ch_i    = ch;
        req_en_i    = en;
        req_div_i   = dv;
        req_per_i   = pr;
        req_dc_i    = dc;
        req_valid_i = 1'b1;
    endtask

    // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
    task automatic wait_accept();
        int k = 0;
        while (!req_ready_o && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 30) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: ready stayed 0 expected 1 at %0t", $time);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic en, input logic [31:0] dv,
                        input logic [31:0] pr, input logic [31:0] dc);
        drive(ch, en, dv, pr, dc);
        wait_accept();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready_o && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 30) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: ready stayed 0 expected 1 at %0t", $time);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_ch_i    = 1'b0;
        req_en_i    = 1'b0;
        req_div_i   = 32'd0;
        req_per_i   = 32'd0;
        req_dc_i    = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_write", 64'(write_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        #1;

        // Channel 1 full configure
        clear_log();
        send(1'b0, 1'b1, 32'd2, 32'd10, 32'd6);
        wait_ready();
        exp_wr(8'h00, 32'd0); exp_wr(8'h04, 32'd2); exp_wr(8'h08, 32'd10);
        exp_wr(8'h0C, 32'd6); exp_wr(8'h00, 32'd7);
        check_log("ch1");
        chk("ch1_done", 64'(n_done), 64'd1);

        // Channel 2 full configure, dc = per-1 is legal
        clear_log();
        send(1'b1, 1'b1, 32'd5, 32'd20, 32'd19);
        wait_ready();
        exp_wr(8'h10, 32'd0); exp_wr(8'h14, 32'd5); exp_wr(8'h18, 32'd20);
        exp_wr(8'h1C, 32'd19); exp_wr(8'h10, 32'd7);
        check_log("ch2");
        chk("ch2_done", 64'(n_done), 64'd1);

        // Illegal requests
        clear_log();
        send(1'b0, 1'b1, 32'd0, 32'd10, 32'd3);
        wait_ready();
        send(1'b0, 1'b1, 32'd4, 32'd0, 32'd0);
        wait_ready();
        send(1'b1, 1'b1, 32'd4, 32'd10, 32'd10);
        wait_ready();
        check_log("illegal");
        chk("illegal_err", 64'(n_err), 64'd3);
        chk("illegal_done", 64'(n_done), 64'd0);

        // All-zero enable request rejected, then disable-only
        clear_log();
        send(1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        wait_ready();
        send(1'b0, 1'b0, 32'd9, 32'd9, 32'd9);
        wait_ready();
        exp_wr(8'h00, 32'd0);
        check_log("dis");
        chk("dis_err", 64'(n_err), 64'd1);
        chk("dis_done", 64'(n_done), 64'd1);

        // Reset during the period write
        clear_log();
        send(1'b0, 1'b1, 32'd3, 32'd30, 32'd4);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
        end
        exp_wr(8'h00, 32'd0); exp_wr(8'h04, 32'd3); exp_wr(8'h08, 32'd30);
        check_log("rstmid");
        chk("rstmid_ready", 64'(req_ready_o), 64'd1);
        chk("rstmid_done", 64'(n_done), 64'd0);

        // Valid held while busy; fields change mid-sequence
        clear_log();
        drive(1'b0, 1'b1, 32'd4, 32'd12, 32'd5);
        wait_accept();
        drive(1'b1, 1'b1, 32'd9, 32'd16, 32'd0);
        wait_accept();
        req_valid_i = 1'b0;
        wait_ready();
        exp_wr(8'h00, 32'd0); exp_wr(8'h04, 32'd4); exp_wr(8'h08, 32'd12);
        exp_wr(8'h0C, 32'd5); exp_wr(8'h00, 32'd7);
        exp_wr(8'h10, 32'd0); exp_wr(8'h14, 32'd9); exp_wr(8'h18, 32'd16);
        exp_wr(8'h1C, 32'd0); exp_wr(8'h10, 32'd7);
        check_log("hold");
        chk("hold_done", 64'(n_done), 64'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
